// File: rtl/maquina_tx_if.sv
// rtl/maquina_tx_if.sv - command/code bus between control logic, maquina_tx and the maquina receiver
interface maquina_tx_if;
    logic       cmd_valid;
    logic [3:0] cmd_target;
    logic       cmd_ready;
    logic [7:0] code_out;
    logic       rx_res;
    logic [3:0] cur_state;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_target,
        input  cmd_ready, code_out, rx_res, cur_state, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_target,
        output cmd_ready, code_out, rx_res, cur_state, busy, done, err
    );
endinterface

// File: rtl/maquina_tx.sv
// rtl/maquina_tx.sv - walks the maquina receiver to a target state with legal one-hop command codes
module maquina_tx #(
    parameter int         HOLD      = 1,
    parameter logic [7:0] IDLE_CODE = 8'h00
) (
    input  logic          clk,
    input  logic          res,
    maquina_tx_if.slave   bus
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RSTRX = 2'd1,
        S_STEP  = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cur_q, cur_d;
    logic [3:0]    target_q, target_d;
    logic [7:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [3:0]    hop;

    function automatic logic [7:0] code_of(input logic [3:0] p);
        logic [7:0] c;
        case (p)
            4'd1:    c = 8'h90;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'h82;
            4'd4:    c = 8'hC7;
            4'd5:    c = 8'hBA;
            4'd9:    c = 8'h9E;
            4'hA:    c = 8'h8D;
            default: c = IDLE_CODE;
        endcase
        return c;
    endfunction

    function automatic logic legal(input logic [3:0] t);
        return (t >= 4'd1 && t <= 4'd5) || t == 4'd9 || t == 4'hA;
    endfunction

    // acao is only reachable from est1..3 and hora only from est4..5
    function automatic logic [3:0] next_hop(input logic [3:0] p, input logic [3:0] t);
        logic [3:0] n;
        if (p == 4'd0) begin
            if (t == 4'd9)      n = 4'd1;
            else if (t == 4'hA) n = 4'd4;
            else                n = t;
        end else if (t == 4'd9) begin
            n = (p <= 4'd3) ? 4'd9 : p - 4'd1;
        end else if (t == 4'hA) begin
            n = (p >= 4'd4) ? 4'hA : p + 4'd1;
        end else if (t > p) begin
            n = p + 4'd1;
        end else begin
            n = p - 4'd1;
        end
        return n;
    endfunction

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        target_d = target_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        hop      = next_hop(cur_q, target_q);
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (!legal(bus.cmd_target)) begin
                        err_d = 1'b1;
                    end else if (bus.cmd_target == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        target_d = bus.cmd_target;
                        // terminal states ignore entrada, so the receiver must be reset first
                        if (cur_q >= 4'd8) begin
                            state_d = S_RSTRX;
                            cur_d   = 4'd0;
                            code_d  = IDLE_CODE;
                        end else begin
                            state_d = S_STEP;
                        end
                    end
                end
            end
            S_RSTRX: state_d = S_STEP;
            S_STEP: begin
                cur_d   = hop;
                code_d  = code_of(hop);
                cnt_d   = CW'(HOLD - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (cur_q == target_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cur_d  = hop;
                    code_d = code_of(hop);
                    cnt_d  = CW'(HOLD - 1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= S_IDLE;
            cur_q    <= 4'd0;
            target_q <= 4'd0;
            code_q   <= IDLE_CODE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.rx_res    = res | (state_q == S_RSTRX);
    assign bus.code_out  = code_q;
    assign bus.cur_state = cur_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule
